// File: rtl/gate_seq_pkg.sv
// Shared types and helpers for the gate window sequencer: FSM state encoding,
// range multipliers and the window timer load computation.
package gate_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_WINDOW = 3'd2,
        ST_HOLD   = 3'd3,
        ST_DONE   = 3'd4
    } gate_state_e;

    localparam int unsigned RANGE_MULT_X1    = 32'd1;
    localparam int unsigned RANGE_MULT_X10   = 32'd10;
    localparam int unsigned RANGE_MULT_X100  = 32'd100;
    localparam int unsigned RANGE_MULT_X1000 = 32'd1000;

    function automatic int unsigned range_mult(input logic [1:0] rng);
        int unsigned mult;
        case (rng)
            2'd0:    mult = RANGE_MULT_X1;
            2'd1:    mult = RANGE_MULT_X10;
            2'd2:    mult = RANGE_MULT_X100;
            2'd3:    mult = RANGE_MULT_X1000;
            default: mult = RANGE_MULT_X1;
        endcase
        return mult;
    endfunction

    // Timer counts load..0 inclusive, so the load is one less than the length.
    function automatic int unsigned window_load(input logic [1:0] rng,
                                                input int unsigned base_len);
        return (base_len * range_mult(rng)) - 32'd1;
    endfunction

endpackage

// File: rtl/gate_timer.sv
// Loadable down-counter shared by the window and hold-off intervals.
// Load has priority over enable; the count saturates at zero.
module gate_timer #(
    parameter int unsigned TMR_WIDTH = 24
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 load_i,
    input  logic [TMR_WIDTH-1:0] load_val_i,
    input  logic                 en_i,
    output logic                 zero_o
);

    localparam logic [TMR_WIDTH-1:0] TMR_ZERO = {TMR_WIDTH{1'b0}};
    localparam logic [TMR_WIDTH-1:0] TMR_ONE  = TMR_WIDTH'(1'b1);

    logic [TMR_WIDTH-1:0] cnt_q;
    logic [TMR_WIDTH-1:0] cnt_d;
    logic                 zero_s;

    assign zero_s = (cnt_q == TMR_ZERO);
    assign zero_o = zero_s;

    // Next count: load, decrement while nonzero, or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && !zero_s) begin
            cnt_d = cnt_q - TMR_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= TMR_ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/gate_window_sequencer.sv
// Gate window sequencer: ARM (counter clear), Gate-high window, hold-off, Done.
// Optional decade window select is enabled by defining WINDOW_SELECT_EN.
module gate_window_sequencer
    import gate_seq_pkg::*;
#(
    parameter int unsigned WINDOW_LEN  = 1000,
    parameter int unsigned HOLDOFF_LEN = 2,
    parameter int unsigned TMR_WIDTH   = 24
) (
    input  logic       Clk,
    input  logic       nReset,
    input  logic       Start,
    input  logic       Continuous,
    input  logic       Abort,
`ifdef WINDOW_SELECT_EN
    input  logic [1:0] Range,
`endif
    output logic       Gate,
    output logic       Busy,
    output logic       Done
);

    localparam logic [TMR_WIDTH-1:0] HOLD_LOAD = TMR_WIDTH'(HOLDOFF_LEN - 32'd1);
    localparam logic [TMR_WIDTH-1:0] TMR_ZERO  = {TMR_WIDTH{1'b0}};

    gate_state_e          state_q;
    gate_state_e          state_d;
    logic                 gate_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 tmr_load_s;
    logic [TMR_WIDTH-1:0] tmr_load_val_s;
    logic                 tmr_en_s;
    logic                 tmr_zero_s;
    logic [TMR_WIDTH-1:0] win_load_s;

`ifdef WINDOW_SELECT_EN
    logic [1:0] range_q;
    logic [1:0] range_d;

    // Window length follows the range latched at the accepted start, not the live port.
    assign win_load_s = TMR_WIDTH'(window_load(range_q, WINDOW_LEN));
`else
    localparam logic [TMR_WIDTH-1:0] WIN_LOAD = TMR_WIDTH'(window_load(2'd0, WINDOW_LEN));

    assign win_load_s = WIN_LOAD;
`endif

    gate_timer #(
        .TMR_WIDTH (TMR_WIDTH)
    ) u_timer (
        .clk_i      (Clk),
        .rst_ni     (nReset),
        .load_i     (tmr_load_s),
        .load_val_i (tmr_load_val_s),
        .en_i       (tmr_en_s),
        .zero_o     (tmr_zero_s)
    );

    // Next-state and timer control; Abort overrides every other transition.
    always_comb begin
        state_d        = state_q;
        tmr_load_s     = 1'b0;
        tmr_load_val_s = TMR_ZERO;
        tmr_en_s       = 1'b0;
`ifdef WINDOW_SELECT_EN
        range_d        = range_q;
`endif
        if (Abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (Start) begin
                        state_d = ST_ARM;
`ifdef WINDOW_SELECT_EN
                        range_d = Range;
`endif
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ARM: begin
                    tmr_load_s     = 1'b1;
                    tmr_load_val_s = win_load_s;
                    state_d        = ST_WINDOW;
                end
                ST_WINDOW: begin
                    if (tmr_zero_s) begin
                        tmr_load_s     = 1'b1;
                        tmr_load_val_s = HOLD_LOAD;
                        state_d        = ST_HOLD;
                    end else begin
                        tmr_en_s = 1'b1;
                        state_d  = ST_WINDOW;
                    end
                end
                ST_HOLD: begin
                    if (tmr_zero_s) begin
                        state_d = ST_DONE;
                    end else begin
                        tmr_en_s = 1'b1;
                        state_d  = ST_HOLD;
                    end
                end
                ST_DONE: begin
                    if (Continuous) begin
                        state_d = ST_ARM;
`ifdef WINDOW_SELECT_EN
                        range_d = Range;
`endif
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and outputs are registered from the next state, so outputs track the state cycle.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= ST_IDLE;
            gate_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef WINDOW_SELECT_EN
            range_q <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            gate_q  <= (state_d == ST_WINDOW);
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= (state_d == ST_DONE);
`ifdef WINDOW_SELECT_EN
            range_q <= range_d;
`endif
        end
    end

    assign Gate = gate_q;
    assign Busy = busy_q;
    assign Done = done_q;

endmodule

// File: tb/tb_gate_window_sequencer.sv
// Scoreboard bench for gate_window_sequencer (WINDOW_LEN=8, HOLDOFF_LEN=2).
// Expected Done events are queued at stimulus time and checked by a monitor.
module tb_gate_window_sequencer;

    localparam int W = 8;
    localparam int H = 2;

    logic       Clk        = 1'b0;
    logic       nReset     = 1'b0;
    logic       Start      = 1'b0;
    logic       Continuous = 1'b0;
    logic       Abort      = 1'b0;
    logic [1:0] Range_s    = 2'd0;
    logic       Gate;
    logic       Busy;
    logic       Done;

    typedef struct {
        int done_at;
        int rise_at;
        int gate_len;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec   = 0;
    int   n_err   = 0;
    int   edge_no = 0;

    gate_window_sequencer #(
        .WINDOW_LEN  (W),
        .HOLDOFF_LEN (H),
        .TMR_WIDTH   (24)
    ) dut (
        .Clk        (Clk),
        .nReset     (nReset),
        .Start      (Start),
        .Continuous (Continuous),
        .Abort      (Abort),
`ifdef WINDOW_SELECT_EN
        .Range      (Range_s),
`endif
        .Gate       (Gate),
        .Busy       (Busy),
        .Done       (Done)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) edge_no <= edge_no + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_no);
        end
    endtask

    // Entry k of a run started at edge s: period is wlen+H+2.
    task automatic push_exp(input int s, input int wlen, input int k);
        exp_t e;
        e.rise_at  = s + 1 + k * (wlen + H + 2);
        e.done_at  = s + wlen + H + 1 + k * (wlen + H + 2);
        e.gate_len = wlen;
        exp_q.push_back(e);
    endtask

    task automatic wait_edge(input int target);
        while (edge_no < target) @(negedge Clk);
    endtask

    // Monitor: measures Gate windows and scores every Done pulse.
    initial begin
        logic gate_prev;
        int   rise_at;
        int   last_len;
        exp_t e;
        gate_prev = 1'b0;
        rise_at   = 0;
        last_len  = 0;
        forever begin
            @(negedge Clk);
            if (Gate === 1'b1 && gate_prev === 1'b0) rise_at = edge_no;
            if (Gate === 1'b0 && gate_prev === 1'b1) last_len = edge_no - rise_at;
            gate_prev = Gate;
            if (Done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", edge_no, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("done_edge", edge_no, e.done_at);
                    check("gate_rise", rise_at, e.rise_at);
                    check("gate_len", last_len, e.gate_len);
                    check("done_busy", Busy, 1'b1);
                end
            end
        end
    end

    // Directed stimulus.
    initial begin
        int s;

        repeat (3) @(negedge Clk);
        check("rst_gate", Gate, 1'b0);
        check("rst_busy", Busy, 1'b0);
        check("rst_done", Done, 1'b0);
        #2 nReset = 1'b1;
        repeat (3) @(negedge Clk);

        // Single shot with extra Start pulses while busy.
        s = edge_no + 1;
        push_exp(s, W, 0);
        for (int off = -1; off <= 13; off++) begin
            if (off >= 0) begin
                check("ss_gate", Gate, (off >= 1 && off <= 8) ? 1'b1 : 1'b0);
                check("ss_busy", Busy, (off <= 11) ? 1'b1 : 1'b0);
                check("ss_done", Done, (off == 11) ? 1'b1 : 1'b0);
            end
            Start = (off == -1 || off == 2 || off == 8);
            @(negedge Clk);
        end
        Start = 1'b0;

        // Start and Abort together in IDLE.
        Start = 1'b1;
        Abort = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        Abort = 1'b0;
        check("sa_busy", Busy, 1'b0);
        check("sa_gate", Gate, 1'b0);
        @(negedge Clk);
        check("sa_busy2", Busy, 1'b0);

        // Abort in window: sampled at edge s+5.
        s = edge_no + 1;
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        wait_edge(s + 4);
        check("ab_pre_gate", Gate, 1'b1);
        Abort = 1'b1;
        @(negedge Clk);
        Abort = 1'b0;
        check("ab_gate", Gate, 1'b0);
        check("ab_busy", Busy, 1'b0);
        check("ab_done", Done, 1'b0);
        repeat (15) @(negedge Clk);

        // Full run after abort.
        s = edge_no + 1;
        push_exp(s, W, 0);
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        wait_edge(s + 13);
        check("post_ab_idle", Busy, 1'b0);

        // Continuous: three Dones, Continuous dropped after the second re-arm.
        s = edge_no + 1;
        for (int k = 0; k < 3; k++) push_exp(s, W, k);
        Start = 1'b1;
        Continuous = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        wait_edge(s + 24);
        Continuous = 1'b0;
        wait_edge(s + 36);
        check("cont_stop_busy", Busy, 1'b0);
        repeat (15) @(negedge Clk);

        // Asynchronous reset mid-window.
        s = edge_no + 1;
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        wait_edge(s + 3);
        check("mr_pre_gate", Gate, 1'b1);
        #2 nReset = 1'b0;
        #1;
        check("mr_gate", Gate, 1'b0);
        check("mr_busy", Busy, 1'b0);
        check("mr_done", Done, 1'b0);
        @(negedge Clk);
        #2 nReset = 1'b1;
        repeat (2) @(negedge Clk);

        s = edge_no + 1;
        push_exp(s, W, 0);
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        wait_edge(s + 13);

`ifdef WINDOW_SELECT_EN
        // Range=2 latched at Start; mid-window change must not alter the window.
        Range_s = 2'd2;
        s = edge_no + 1;
        push_exp(s, W * 100, 0);
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        wait_edge(s + 100);
        Range_s = 2'd0;
        wait_edge(s + W * 100 + H + 3);
        check("rg_idle", Busy, 1'b0);

        s = edge_no + 1;
        push_exp(s, W, 0);
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        wait_edge(s + 13);
`endif

        repeat (20) @(negedge Clk);
        check("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
